// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
// The optional retire counter (WB_RETIRE_COUNT_EN) uses RC_W / RC_MAX.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

    // Retire counter width and its saturation value
    localparam int            RC_W   = 16;
    localparam logic [RC_W-1:0] RC_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } wb_state_e;

    // Address of the upper half of a wide result; wraps around the register file
    function automatic logic [WB_ADDR_W-1:0] hi_addr_of(input logic [WB_ADDR_W-1:0] dst);
        return dst + {{(WB_ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/wb_if.sv
// Retire handshake from the memory stage plus the register-file write port.
// slave = write-back stage view, master = upstream / register-file view.
interface wb_if
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
);

    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic              in_wide;
    logic [ADDR_W-1:0] in_dst_addr;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_high_data;

    logic              write_back;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              busy;

    modport slave (
        input  in_valid, in_reg_write, in_mem_to_reg, in_wide,
               in_dst_addr, in_alu_result, in_mem_data, in_high_data,
        output in_ready, write_back, write_addr, write_data, busy
    );

    modport master (
        output in_valid, in_reg_write, in_mem_to_reg, in_wide,
               in_dst_addr, in_alu_result, in_mem_data, in_high_data,
        input  in_ready, write_back, write_addr, write_data, busy
    );

endinterface

// File: rtl/wb_result_mux.sv
// Selects the retiring value: load data when mem_to_reg, otherwise the ALU result.
module wb_result_mux #(
    parameter int DATA_W = 16
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] result
);

    assign result = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: registers retiring results onto the register-file write port,
// splitting wide results over two cycles. WB_RETIRE_COUNT_EN adds retire_count.
module write_back_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    wb_if.slave  bus
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [RC_W-1:0] retire_count
`endif
);

    wb_state_e         state, next_state;
    logic              hi_pend;
    logic [ADDR_W-1:0] hi_addr;
    logic [DATA_W-1:0] hi_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              ready;
    logic              accept;
    logic              take_write;
    logic              emit_high;
    logic [DATA_W-1:0] sel_data;

    wb_result_mux #(.DATA_W(DATA_W)) u_mux (
        .mem_to_reg (bus.in_mem_to_reg),
        .alu_result (bus.in_alu_result),
        .mem_data   (bus.in_mem_data),
        .result     (sel_data)
    );

    // The cycle presenting the low half of a wide result already owns the next
    // cycle for the high half, so nothing new may be accepted at its closing edge.
    assign emit_high  = (state == S_LO) && hi_pend;
    assign ready      = !reset && !emit_high;
    assign accept     = bus.in_valid && ready;
    assign take_write = accept && bus.in_reg_write;

    always_comb begin
        next_state = S_IDLE;
        if (emit_high)
            next_state = S_HI;
        else if (take_write)
            next_state = S_LO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            hi_pend <= 1'b0;
            hi_addr <= '0;
            hi_data <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= next_state;
            wr_en <= 1'b0;
            if (emit_high) begin
                wr_en   <= 1'b1;
                wr_addr <= hi_addr;
                wr_data <= hi_data;
                hi_pend <= 1'b0;
            end else if (take_write) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.in_dst_addr;
                wr_data <= sel_data;
                hi_pend <= bus.in_wide;
                hi_addr <= bus.in_dst_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                hi_data <= bus.in_high_data;
            end else begin
                // bubble or idle: address/data hold, only the enable drops
                hi_pend <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.write_back = wr_en;
    assign bus.write_addr = wr_addr;
    assign bus.write_data = wr_data;
    assign bus.busy       = emit_high || (state == S_HI);

`ifdef WB_RETIRE_COUNT_EN
    logic [RC_W-1:0] rc;

    always_ff @(posedge clk) begin
        if (reset)
            rc <= '0;
        else if (wr_en && rc != RC_MAX)
            rc <= rc + 1'b1;
    end

    assign retire_count = rc;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed literal checks plus randomized traffic
// compared every cycle against a behavioural write-sequence model.
module tb_write_back_stage;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    wb_if #(.DATA_W(16), .ADDR_W(3)) bus ();

`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] retire_count;
`endif

    write_back_stage #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of scheduled writes. An accepted wide write books two
    // slots, and the stage is not ready while the second slot is still queued.
    typedef struct { logic [2:0] addr; logic [15:0] data; bit high; } wr_t;
    wr_t         sched[$];
    bit          m_we = 0, m_high = 0, last_acc = 0;
    logic [2:0]  m_addr = 0;
    logic [15:0] m_data = 0;
    int unsigned m_cnt = 0;
    wr_t         w;

    always @(posedge clk) begin
        last_acc = bus.in_valid && !reset && (sched.size() == 0);
        if (reset) m_cnt = 0;
        else if (m_we && m_cnt < 65535) m_cnt++;
        if (reset) begin
            sched.delete();
            m_we = 0; m_high = 0; m_addr = 0; m_data = 0;
        end else begin
            if (last_acc && bus.in_reg_write) begin
                w.addr = bus.in_dst_addr;
                w.data = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;
                w.high = 0;
                sched.push_back(w);
                if (bus.in_wide) begin
                    w.addr = 3'((int'(bus.in_dst_addr) + 1) % 8);
                    w.data = bus.in_high_data;
                    w.high = 1;
                    sched.push_back(w);
                end
            end
            if (sched.size() > 0) begin
                w = sched.pop_front();
                m_we = 1; m_addr = w.addr; m_data = w.data; m_high = w.high;
            end else begin
                m_we = 0; m_high = 0;
            end
        end
        #1;
        chk("m_write_back", 32'(bus.write_back), 32'(m_we));
        if (m_we || reset) begin
            chk("m_write_addr", 32'(bus.write_addr), 32'(m_addr));
            chk("m_write_data", 32'(bus.write_data), 32'(m_data));
        end
        chk("m_busy", 32'(bus.busy), 32'(sched.size() > 0 || m_high));
        chk("m_in_ready", 32'(bus.in_ready), 32'(!reset && sched.size() == 0));
`ifdef WB_RETIRE_COUNT_EN
        chk("m_retire_count", 32'(retire_count), m_cnt);
`endif
    end

    task automatic drive(input bit v, input bit rw, input bit mtr, input bit wide,
                         input logic [2:0] dst, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] hi);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_mem_to_reg = mtr;
        bus.in_wide       = wide;
        bus.in_dst_addr   = dst;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mem;
        bus.in_high_data  = hi;
    endtask

    // Apply at the falling edge, then stop just after the next rising edge
    task automatic cyc(input bit v, input bit rw, input bit mtr, input bit wide,
                       input logic [2:0] dst, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [15:0] hi);
        @(negedge clk);
        drive(v, rw, mtr, wide, dst, alu, mem, hi);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic wr_chk(input string name, input bit we, input logic [2:0] a, input logic [15:0] d);
        chk({name, "_we"}, 32'(bus.write_back), 32'(we));
        chk({name, "_addr"}, 32'(bus.write_addr), 32'(a));
        chk({name, "_data"}, 32'(bus.write_data), 32'(d));
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1, 1, 0, 0, 3'd6, 16'hDEAD, 16'hC0DE, 16'h0);
        // reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            wr_chk("rst", 0, 3'd0, 16'h0);
            chk("rst_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
        #1 chk("rst_ready_after", 32'(bus.in_ready), 32'd1);

        // single ALU write, then idle
        cyc(1, 1, 0, 0, 3'd3, 16'h1234, 16'h9999, 16'h0);
        wr_chk("alu", 1, 3'd3, 16'h1234);
        idle_cyc();
        chk("alu_idle_we", 32'(bus.write_back), 32'd0);

        // back-to-back load then ALU, then a bubble that holds addr/data
        cyc(1, 1, 1, 0, 3'd2, 16'h1111, 16'hBEEF, 16'h0);
        wr_chk("b2b_load", 1, 3'd2, 16'hBEEF);
        chk("b2b_ready", 32'(bus.in_ready), 32'd1);
        cyc(1, 1, 0, 0, 3'd5, 16'h0007, 16'h2222, 16'h0);
        wr_chk("b2b_alu", 1, 3'd5, 16'h0007);
        cyc(1, 0, 0, 0, 3'd1, 16'h3333, 16'h4444, 16'h0);
        wr_chk("bubble", 0, 3'd5, 16'h0007);

        // wide result at dst=7 wraps its high half to register 0
        cyc(1, 1, 0, 1, 3'd7, 16'hAAAA, 16'h1212, 16'h5555);
        wr_chk("wide_lo", 1, 3'd7, 16'hAAAA);
        chk("wide_lo_ready", 32'(bus.in_ready), 32'd0);
        chk("wide_lo_busy", 32'(bus.busy), 32'd1);
        cyc(1, 1, 0, 0, 3'd4, 16'h0F0F, 16'h0, 16'h0);  // held, not yet accepted
        wr_chk("wide_hi", 1, 3'd0, 16'h5555);
        chk("wide_hi_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #2;
        wr_chk("wide_next", 1, 3'd4, 16'h0F0F);

        // wide with load data as the low half
        cyc(1, 1, 1, 1, 3'd3, 16'h0101, 16'hCAFE, 16'hF00D);
        wr_chk("wide_mem_lo", 1, 3'd3, 16'hCAFE);
        idle_cyc();
        wr_chk("wide_mem_hi", 1, 3'd4, 16'hF00D);
        // wide with reg_write=0 is only a bubble
        cyc(1, 0, 0, 1, 3'd6, 16'h7777, 16'h0, 16'h8888);
        chk("wide_bubble_we", 32'(bus.write_back), 32'd0);
        idle_cyc();
        chk("wide_bubble_we2", 32'(bus.write_back), 32'd0);

        // reset during the low-half cycle discards the high half
        cyc(1, 1, 0, 1, 3'd1, 16'h1111, 16'h0, 16'h2222);
        wr_chk("rmw_lo", 1, 3'd1, 16'h1111);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
        @(posedge clk); #2;
        wr_chk("rmw_rst", 0, 3'd0, 16'h0);
        chk("rmw_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("rmw_no_hi", 32'(bus.write_back), 32'd0);
        chk("rmw_ready", 32'(bus.in_ready), 32'd1);

`ifdef WB_RETIRE_COUNT_EN
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        cyc(1, 1, 0, 0, 3'd2, 16'h1, 16'h0, 16'h0);
        cyc(1, 1, 0, 1, 3'd4, 16'h2, 16'h0, 16'h3);
        idle_cyc(); idle_cyc(); idle_cyc();
        chk("rc_three", 32'(retire_count), 32'd3);
        cyc(1, 1, 0, 0, 3'd1, 16'h5, 16'h0, 16'h0);
        repeat (65540) @(posedge clk);
        #2 chk("rc_sat", 32'(retire_count), 32'hFFFF);
        idle_cyc();
`endif

        // randomized traffic; an unaccepted instruction is held stable
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 79) == 0);
            if (!(bus.in_valid && !last_acc))
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                      3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
